// File: rtl/sigmoid_pwl_ctrl_if.sv
// Handshake bundle for the piecewise-linear sigmoid sequencer.
// The master side supplies samples and consumes results; the slave side is the sequencer.
interface sigmoid_pwl_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sigmoid_pwl_ctrl.sv
// Piecewise-linear sigmoid sequencer: one signed Q8.8 sample in, one unsigned
// Q8.8 result out, via IDLE -> ABS -> SEG -> EVAL -> MIRROR -> DONE.
// Slopes are powers of two, so evaluation uses shifts only.
// Optional build macro SIGMOID_SEG_DBG_EN adds seg_dbg/sat_dbg outputs that
// report the segment of the result currently presented.
module sigmoid_pwl_ctrl #(
    parameter int                DATA_W = 16,
    parameter int                FRAC_W = 8,
    parameter logic [DATA_W-1:0] BP1    = 16'h0100,
    parameter logic [DATA_W-1:0] BP2    = 16'h0260,
    parameter logic [DATA_W-1:0] BP3    = 16'h0500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sigmoid_pwl_ctrl_if.slave     bus
`ifdef SIGMOID_SEG_DBG_EN
    ,
    output logic [1:0]            seg_dbg,
    output logic                  sat_dbg
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ABS    = 3'd1;
    localparam logic [2:0] ST_SEG    = 3'd2;
    localparam logic [2:0] ST_EVAL   = 3'd3;
    localparam logic [2:0] ST_MIRROR = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // 1.0 in the working fixed-point format; 0.5 is the curve value at x=0
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] HALF     = ONE >> 1;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [3*DATA_W-1:0] BP_TAB = {BP3, BP2, BP1};

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [DATA_W-1:0] x_reg;
    logic              sign_reg;
    logic              sat_reg;
    logic [DATA_W-1:0] a_reg;
    logic [1:0]        seg_reg;
    logic [DATA_W-1:0] y_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic [2:0]        a_ge;
    logic [1:0]        seg_cmp;
    logic [DATA_W-1:0] y_mirror;
    logic [DATA_W-1:0] y_clamped;
`ifdef SIGMOID_SEG_DBG_EN
    logic [1:0]        seg_dbg_reg;
    logic              sat_dbg_reg;
`endif

    // One unsigned magnitude comparator per breakpoint
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bp_cmp
            assign a_ge[gi] = (a_reg >= BP_TAB[gi*DATA_W +: DATA_W]);
        end
    endgenerate

    // Breakpoints are ascending, so the comparator vector is a thermometer code
    always_comb begin
        seg_cmp = 2'd3;
        case (a_ge)
            3'b000:  seg_cmp = 2'd0;
            3'b001:  seg_cmp = 2'd1;
            3'b011:  seg_cmp = 2'd2;
            default: seg_cmp = 2'd3;
        endcase
    end

    // Negative inputs reflect around 0.5: ~y + 0x0101 == 1.0 - y; clamp to 1.0
    always_comb begin
        y_mirror  = sign_reg ? (~y_reg + (ONE + DATA_W'(1))) : y_reg;
        y_clamped = (y_mirror > ONE) ? ONE : y_mirror;
    end

    // Next-state: one cycle per stage, DONE waits for the consumer
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.in_valid) state_next = ST_ABS;
            ST_ABS:    state_next = ST_SEG;
            ST_SEG:    state_next = ST_EVAL;
            ST_EVAL:   state_next = ST_MIRROR;
            ST_MIRROR: state_next = ST_DONE;
            ST_DONE:   if (bus.out_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register and per-stage datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            x_reg         <= '0;
            sign_reg      <= 1'b0;
            sat_reg       <= 1'b0;
            a_reg         <= '0;
            seg_reg       <= 2'd0;
            y_reg         <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        x_reg    <= bus.in_data;
                        sign_reg <= bus.in_data[DATA_W-1];
                    end
                end
                ST_ABS: begin
                    // The most negative code has no positive twin; force saturation
                    if (x_reg == MOST_NEG) begin
                        sat_reg <= 1'b1;
                        a_reg   <= BP3;
                    end else begin
                        sat_reg <= 1'b0;
                        a_reg   <= sign_reg ? (-x_reg) : x_reg;
                    end
                end
                ST_SEG: begin
                    seg_reg <= sat_reg ? 2'd3 : seg_cmp;
                end
                ST_EVAL: begin
                    case (seg_reg)
                        2'd0:    y_reg <= (a_reg >> 2) + HALF;
                        2'd1:    y_reg <= (a_reg >> 3) + DATA_W'(16'h00A0);
                        2'd2:    y_reg <= (a_reg >> 5) + DATA_W'(16'h00D8);
                        default: y_reg <= ONE;
                    endcase
                end
                ST_MIRROR: begin
                    out_data_reg  <= y_clamped;
                    out_valid_reg <= 1'b1;
                end
                ST_DONE: begin
                    if (bus.out_ready) out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SIGMOID_SEG_DBG_EN
    // Segment tag captured alongside the result so it stays valid with out_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_dbg_reg <= 2'd0;
            sat_dbg_reg <= 1'b0;
        end else if (state_reg == ST_MIRROR) begin
            seg_dbg_reg <= seg_reg;
            sat_dbg_reg <= (seg_reg == 2'd3);
        end
    end

    assign seg_dbg = seg_dbg_reg;
    assign sat_dbg = sat_dbg_reg;
`endif

    assign bus.in_ready  = (state_reg == ST_IDLE);
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;

endmodule
